fifo_rd_stream_adapter: RTL and testbench
=========================================

// Module: fifo_rd_stream_adapter
// PURPOSE
// - Read-domain consumer of the async FIFO read-pointer stage: turns rd_empty/rd_data into a valid/ready stream.
// - Issues rd_inc pops, buffers popped words in a small register buffer, and keeps the downstream consumer
//   (e.g. serial TX) decoupled so out_ready never combinationally drives rd_inc.
// - Sits between the FIFO read side (pointer logic + memory read port) and the read-domain consumer.
// PARAMETERS
// - DATA_WIDTH  8   width of FIFO words and out_data
// - BUF_DEPTH   2   output buffer entries; power of two, >= 2
// - CNT_WIDTH   16  width of delivered-word counter word_cnt
// PORTS
// - R_CLK      in   1              read-domain clock; all logic on posedge
// - R_RST      in   1              reset, synchronous, active-high
// - rd_empty   in   1              FIFO empty flag from the read-pointer stage
// - rd_data    in   DATA_WIDTH     FIFO memory read data at the current read address; combinational, valid while rd_empty=0
// - rd_inc     out  1              pop request to the read-pointer stage
// - out_ready  in   1              consumer accepts out_data this cycle
// - out_valid  out  1              out_data holds a valid word
// - out_data   out  DATA_WIDTH     head word of the output buffer
// - buf_level  out  $clog2(BUF_DEPTH)+1  current buffer occupancy
// - word_cnt   out  CNT_WIDTH      words handed to consumer since reset
// BEHAVIOUR
// - Reset (R_RST=1 at posedge): buf_level=0, wr/rd indices=0, out_valid=0, out_data=0, word_cnt=0; rd_inc=0 throughout reset.
// - push = rd_inc = ~R_RST & ~rd_empty & (buf_level < BUF_DEPTH). No dependence on out_ready (no comb path ready->rd_inc).
// - On push: rd_data written into buf[wr_idx] at the same posedge the FIFO pointer advances; wr_idx wraps mod BUF_DEPTH.
// - pop = out_valid & out_ready; on pop rd_idx wraps mod BUF_DEPTH and word_cnt increments.
// - out_valid = (buf_level != 0); out_data = buf[rd_idx]; out_data = 0 when buffer empty (no X on bus).
// - buf_level next = level + push - pop; simultaneous push and pop leaves level unchanged.
//   Simultaneous push+pop at level==BUF_DEPTH is impossible (push gated on current level).
// - Latency: FIFO non-empty with buffer empty -> rd_inc high cycle N, out_valid high cycle N+1, same word on out_data.
// - Throughput: one word/cycle sustained while rd_empty=0 and out_ready=1 (level settles at 1).
// - Backpressure: out_ready=0 -> buffer fills to BUF_DEPTH, then rd_inc drops; FIFO holds remaining data.
// - Word order strictly preserved; no drops, no duplicates.
// - Handshake: out_data/out_valid stay stable while out_valid=1 and out_ready=0.
// - word_cnt wraps from 2^CNT_WIDTH-1 to 0 silently.
// - rd_empty toggling with rd_inc: rd_inc is a pure function of current rd_empty; the pointer stage re-gates it.
// - Reset mid-operation: buffered words discarded; FIFO pointers not reset by this block. System-level reset of both domains
//   restores consistency; words already popped are lost by design.
// STRUCTURE
// - Shared package/header async_fifo_pkg: default DATA_WIDTH, ADDR_WIDTH, BUF_DEPTH constants shared with the
//   write and read pointer stages.
// - One module. Buffer register file + wrapping index counters inline; no FSM beyond buf_level (EMPTY/PARTIAL/FULL derived).
// - Optional sub-module fifo_rd_skid_buf (register array + indices) if reused elsewhere; not required.
// TESTING
// - Reset: hold R_RST=1 with rd_empty=0 -> rd_inc=0, out_valid=0, out_data=0, buf_level=0, word_cnt=0.
// - Single word: rd_empty 1->0 at cycle N, rd_data=8'hA5, out_ready=0 -> rd_inc=1 at N;
//   out_valid=1, out_data=A5, buf_level=1 at N+1.
// - Streaming: FIFO holds 8'h01..8'h08, out_ready=1 -> outputs 01..08 on consecutive cycles after first,
//   word_cnt=8, buf_level returns to 0.
// - Backpressure: 5 words queued, out_ready=0 -> exactly 2 pops, buf_level=2, rd_inc=0;
//   out_data stable at first word. Release -> remaining 3 delivered in order.
// - Push+pop same cycle at level 1 -> level stays 1, word_cnt +1, order intact.
// - Mid-stream reset: R_RST=1 for 1 cycle at level 2 -> next cycle level=0, out_valid=0, word_cnt=0;
//   subsequent pops resume from current FIFO head.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// ---------------------------------------------------------------------------
// async_fifo_pkg
// Shared constants for the async FIFO write/read pointer stages and the
// read-side stream adapter, plus the buffer occupancy classification used
// by the adapter.
// Ports: none (package).
// ---------------------------------------------------------------------------
package async_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_BUF_DEPTH  = 2;
  localparam int DEF_CNT_WIDTH  = 16;

  // Occupancy class of the adapter's output buffer
  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_PARTIAL = 2'd1,
    BUF_FULL    = 2'd2
  } buf_state_e;

  // Classify a buffer level against its depth
  function automatic buf_state_e buf_state(input int level, input int depth);
    buf_state_e st;
    if (level <= 0) begin
      st = BUF_EMPTY;
    end else if (level >= depth) begin
      st = BUF_FULL;
    end else begin
      st = BUF_PARTIAL;
    end
    return st;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream_adapter
// Read-domain consumer of the async FIFO read-pointer stage. Pops words from
// the FIFO into a small circular register buffer and presents them to the
// downstream consumer as a valid/ready stream. rd_inc depends only on
// rd_empty, reset and the registered buffer level, never on out_ready.
//
// Ports:
//   R_CLK      in   read-domain clock (posedge)
//   R_RST      in   synchronous active-high reset
//   rd_empty   in   FIFO empty flag
//   rd_data    in   FIFO read data at the current read address
//   rd_inc     out  pop request to the read-pointer stage
//   out_ready  in   consumer accepts out_data this cycle
//   out_valid  out  out_data holds a valid word
//   out_data   out  head word of the buffer (zero when empty)
//   buf_level  out  buffer occupancy
//   word_cnt   out  words handed to the consumer since reset (wraps)
// ---------------------------------------------------------------------------
module fifo_rd_stream_adapter
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BUF_DEPTH  = DEF_BUF_DEPTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                        R_CLK,
  input  logic                        R_RST,
  input  logic                        rd_empty,
  input  logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_inc,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [$clog2(BUF_DEPTH):0]  buf_level,
  output logic [CNT_WIDTH-1:0]        word_cnt
);

  localparam int IDX_W = $clog2(BUF_DEPTH);
  localparam int LVL_W = IDX_W + 1;

  logic [DATA_WIDTH-1:0] buf_r [BUF_DEPTH];
  logic [IDX_W-1:0]      wr_idx_r;
  logic [IDX_W-1:0]      rd_idx_r;
  logic [LVL_W-1:0]      level_r;
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [CNT_WIDTH-1:0]  word_cnt_r;

  buf_state_e            buf_state_s;
  logic                  push_s;
  logic                  pop_s;
  logic [LVL_W-1:0]      remain_s;
  logic [LVL_W-1:0]      level_nxt_s;
  logic [IDX_W-1:0]      rd_idx_nxt_s;
  logic [DATA_WIDTH-1:0] head_nxt_s;

  // Push/pop decisions and next-state head word of the buffer
  always_comb begin
    buf_state_s = buf_state(int'(level_r), BUF_DEPTH);
    if (!R_RST && !rd_empty && (buf_state_s != BUF_FULL)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    pop_s        = out_valid_r & out_ready;
    // A pop only happens when out_valid_r=1, i.e. level_r>0, so no underflow
    remain_s     = level_r - LVL_W'(pop_s);
    level_nxt_s  = remain_s + LVL_W'(push_s);
    // Indices are log2(BUF_DEPTH) bits wide, so +1 wraps mod BUF_DEPTH
    rd_idx_nxt_s = rd_idx_r + IDX_W'(pop_s);
    // When nothing survives the pop, the new head is the word being pushed
    // now (it lands at wr_idx_r, which equals rd_idx_nxt_s in that case).
    if (level_nxt_s == {LVL_W{1'b0}}) begin
      head_nxt_s = {DATA_WIDTH{1'b0}};
    end else if (remain_s == {LVL_W{1'b0}}) begin
      head_nxt_s = rd_data;
    end else begin
      head_nxt_s = buf_r[rd_idx_nxt_s];
    end
  end

  // Buffer storage, indices, level, registered stream outputs and counter
  always_ff @(posedge R_CLK) begin
    if (R_RST) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_r[i] <= {DATA_WIDTH{1'b0}};
      end
      wr_idx_r    <= {IDX_W{1'b0}};
      rd_idx_r    <= {IDX_W{1'b0}};
      level_r     <= {LVL_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_WIDTH{1'b0}};
      word_cnt_r  <= {CNT_WIDTH{1'b0}};
    end else begin
      if (push_s) begin
        buf_r[wr_idx_r] <= rd_data;
        wr_idx_r        <= wr_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
      end else begin
        wr_idx_r        <= wr_idx_r;
      end
      if (pop_s) begin
        word_cnt_r <= word_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        word_cnt_r <= word_cnt_r;
      end
      rd_idx_r    <= rd_idx_nxt_s;
      level_r     <= level_nxt_s;
      out_valid_r <= (level_nxt_s != {LVL_W{1'b0}});
      out_data_r  <= head_nxt_s;
    end
  end

  assign rd_inc    = push_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign buf_level = level_r;
  assign word_cnt  = word_cnt_r;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_stream_adapter
// Self-checking bench: a queue models the FIFO read side (rd_empty/rd_data
// follow the queue head, a word leaves the queue on each posedge with
// rd_inc=1). A vector table covers reset, single word, backpressure and
// push+pop at level 1; hand sequences cover streaming and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_fifo_rd_stream_adapter;

  logic        R_CLK;
  logic        R_RST;
  logic        rd_empty;
  logic [7:0]  rd_data;
  logic        rd_inc;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  buf_level;
  logic [15:0] word_cnt;

  logic [7:0]  fifo_q [$];
  logic [7:0]  popped;
  logic        inc_seen;
  int          n_chk;
  int          n_fail;

  typedef struct {
    logic        rst;
    logic        add;
    logic [7:0]  word;
    logic        rdy;
    logic        e_inc;
    logic        e_valid;
    logic [7:0]  e_data;
    logic [1:0]  e_level;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [15];

  fifo_rd_stream_adapter #(
    .DATA_WIDTH(8),
    .BUF_DEPTH (2),
    .CNT_WIDTH (16)
  ) dut (
    .R_CLK    (R_CLK),
    .R_RST    (R_RST),
    .rd_empty (rd_empty),
    .rd_data  (rd_data),
    .rd_inc   (rd_inc),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .buf_level(buf_level),
    .word_cnt (word_cnt)
  );

  initial begin
    R_CLK = 1'b0;
    forever #5 R_CLK = ~R_CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    rd_empty = (fifo_q.size() == 0);
    rd_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  // One clock: check rd_inc before the edge, model the FIFO pop at the edge
  task automatic cycle(input string tag, input logic e_inc);
    drive_fifo();
    #1;
    chk($sformatf("%s rd_inc", tag), 32'(rd_inc), 32'(e_inc));
    inc_seen = rd_inc;
    @(posedge R_CLK);
    if (inc_seen) popped = fifo_q.pop_front();
    #1;
    drive_fifo();
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic [1:0] l, input logic [15:0] c);
    chk($sformatf("%s out_valid", tag), 32'(out_valid), 32'(v));
    chk($sformatf("%s out_data", tag),  32'(out_data),  32'(d));
    chk($sformatf("%s buf_level", tag), 32'(buf_level), 32'(l));
    chk($sformatf("%s word_cnt", tag),  32'(word_cnt),  32'(c));
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    R_RST     = 1'b1;
    out_ready = 1'b0;
    rd_empty  = 1'b1;
    rd_data   = 8'h00;
    inc_seen  = 1'b0;
    popped    = 8'h00;

    //            rst   add   word   rdy  | inc   valid data   lvl   cnt
    tbl[0]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 16'd0};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 2'd1, 16'd0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 2'd1, 16'd0};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 16'd1};
    tbl[5]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 2'd1, 16'd1};
    tbl[6]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 2'd2, 16'd1};
    tbl[7]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 2'd2, 16'd1};
    tbl[8]  = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h11, 2'd2, 16'd1};
    tbl[9]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11, 2'd2, 16'd1};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 2'd1, 16'd2};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 2'd1, 16'd3};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 2'd1, 16'd4};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h55, 2'd1, 16'd5};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 16'd6};

    for (int i = 0; i < 15; i++) begin
      R_RST     = tbl[i].rst;
      out_ready = tbl[i].rdy;
      if (tbl[i].add) fifo_q.push_back(tbl[i].word);
      cycle($sformatf("vec%0d", i), tbl[i].e_inc);
      chk_out($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_data,
              tbl[i].e_level, tbl[i].e_cnt);
    end

    // Streaming 01..08 with out_ready held high, after a fresh reset
    R_RST     = 1'b1;
    out_ready = 1'b0;
    cycle("strm_rst", 1'b0);
    chk_out("strm_rst", 1'b0, 8'h00, 2'd0, 16'd0);
    R_RST = 1'b0;
    for (int k = 1; k <= 8; k++) fifo_q.push_back(8'(k));
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycle($sformatf("strm%0d", k), 1'b1);
      chk_out($sformatf("strm%0d", k), 1'b1, 8'(k), 2'd1, 16'(k - 1));
    end
    cycle("strm_end", 1'b0);
    chk_out("strm_end", 1'b0, 8'h00, 2'd0, 16'd8);

    // Mid-stream reset at level 2: buffered words dropped, FIFO head survives
    out_ready = 1'b0;
    fifo_q.push_back(8'hA1);
    fifo_q.push_back(8'hA2);
    fifo_q.push_back(8'hA3);
    cycle("mid1", 1'b1);
    chk_out("mid1", 1'b1, 8'hA1, 2'd1, 16'd8);
    cycle("mid2", 1'b1);
    chk_out("mid2", 1'b1, 8'hA1, 2'd2, 16'd8);
    R_RST = 1'b1;
    cycle("mid_rst", 1'b0);
    chk_out("mid_rst", 1'b0, 8'h00, 2'd0, 16'd0);
    R_RST = 1'b0;
    cycle("mid_resume", 1'b1);
    chk_out("mid_resume", 1'b1, 8'hA3, 2'd1, 16'd0);
    out_ready = 1'b1;
    cycle("mid_drain", 1'b0);
    chk_out("mid_drain", 1'b0, 8'h00, 2'd0, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
